// File: rtl/ibex_defines.sv
// Shared types and constants for the interrupt arbitration logic.
package ibex_defines;
    localparam int IRQ_ID_W = 5;

    typedef enum logic [1:0] {
        IRQ_ARB_IDLE,
        IRQ_ARB_REQ,
        IRQ_ARB_SERVICE
    } irq_arb_state_e;
endpackage

// File: rtl/ibex_irq_prio_enc.sv
// Find-first-set over the request vector; the lowest index has the highest priority.
module ibex_irq_prio_enc
    import ibex_defines::*;
#(
    parameter int N_IRQ = 32
) (
    input  logic [N_IRQ-1:0]    req,
    output logic [IRQ_ID_W-1:0] sel,
    output logic                any
);

    // Scanning downwards means the last hit written is the lowest set bit.
    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = IRQ_ID_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Fixed-priority interrupt arbiter with per-source claim/complete tracking.
// A claimed source stays masked until its completion arrives.
module ibex_irq_arbiter
    import ibex_defines::*;
#(
    parameter int N_IRQ = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IRQ-1:0]    irq_src_i,
    input  logic [N_IRQ-1:0]    irq_en_i,
    input  logic                irq_ack_i,
    input  logic                irq_kill_i,
    input  logic                irq_cmpl_i,
    input  logic [IRQ_ID_W-1:0] irq_cmpl_id_i,
    output logic                irq_o,
    output logic [IRQ_ID_W-1:0] irq_id_o,
    output logic [N_IRQ-1:0]    irq_pending_o,
    output logic [N_IRQ-1:0]    irq_busy_o
);

    irq_arb_state_e        state_q;
    logic                  irq_q;
    logic [IRQ_ID_W-1:0]   id_q;
    logic [N_IRQ-1:0]      pending_q;
    logic [N_IRQ-1:0]      busy_q;

    logic [N_IRQ-1:0]      cand;
    logic [N_IRQ-1:0]      busy_set;
    logic [N_IRQ-1:0]      busy_clr;
    logic [IRQ_ID_W-1:0]   sel;
    logic                  any;

    // Completion ids outside the source range match no bit and are dropped.
    always_comb begin
        cand     = pending_q & ~busy_q;
        busy_set = '0;
        busy_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            busy_set[i] = (state_q == IRQ_ARB_REQ) && irq_ack_i && (id_q == IRQ_ID_W'(i));
            busy_clr[i] = irq_cmpl_i && (irq_cmpl_id_i == IRQ_ID_W'(i));
        end
    end

    ibex_irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio_enc (
        .req (cand),
        .sel (sel),
        .any (any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IRQ_ARB_IDLE;
            irq_q     <= 1'b0;
            id_q      <= '0;
            pending_q <= '0;
            busy_q    <= '0;
        end else begin
            pending_q <= irq_src_i & irq_en_i & ~busy_q;
            // Set is ORed in last so an ack beats a same-cycle completion of that bit.
            busy_q    <= (busy_q & ~busy_clr) | busy_set;
            case (state_q)
                IRQ_ARB_IDLE: begin
                    if (any) begin
                        id_q    <= sel;
                        irq_q   <= 1'b1;
                        state_q <= IRQ_ARB_REQ;
                    end
                end
                IRQ_ARB_REQ: begin
                    if (irq_ack_i) begin
                        irq_q   <= 1'b0;
                        state_q <= IRQ_ARB_SERVICE;
                    end else if (irq_kill_i) begin
                        irq_q   <= 1'b0;
                        state_q <= IRQ_ARB_IDLE;
                    end
                end
                IRQ_ARB_SERVICE: begin
                    if (irq_cmpl_i && (irq_cmpl_id_i == id_q)) begin
                        state_q <= IRQ_ARB_IDLE;
                    end
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= IRQ_ARB_IDLE;
                end
            endcase
        end
    end

    assign irq_o         = irq_q;
    assign irq_id_o      = id_q;
    assign irq_pending_o = pending_q;
    assign irq_busy_o    = busy_q;

endmodule
